// File: rtl/cbus_arbiter.sv
// Round-robin arbiter granting whole cbus transactions (single or burst) to one master at a time.
// Latency: a request seen in IDLE reaches o_* on the next cycle; one IDLE bubble follows every last beat.
// Backpressure: o_ready/o_last/o_rdata pass straight to the granted master; waiting masters see m_ready=0.
module cbus_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_valid,
  input  logic [NUM_MASTERS-1:0]    m_is_write,
  input  logic [3*NUM_MASTERS-1:0]  m_size,
  input  logic [32*NUM_MASTERS-1:0] m_addr,
  input  logic [4*NUM_MASTERS-1:0]  m_strobe,
  input  logic [32*NUM_MASTERS-1:0] m_data,
  input  logic [4*NUM_MASTERS-1:0]  m_len,
  output logic [NUM_MASTERS-1:0]    m_ready,
  output logic [NUM_MASTERS-1:0]    m_last,
  output logic [32*NUM_MASTERS-1:0] m_rdata,
  output logic                      o_valid,
  output logic                      o_is_write,
  output logic [2:0]                o_size,
  output logic [31:0]               o_addr,
  output logic [3:0]                o_strobe,
  output logic [31:0]               o_data,
  output logic [3:0]                o_len,
  input  logic                      o_ready,
  input  logic                      o_last,
  input  logic [31:0]               o_rdata,
  output logic                      busy,
  output logic [1:0]                grant
);

  typedef struct packed {
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } req_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int         IW       = (NUM_MASTERS > 2) ? 2 : 1;
  localparam logic [1:0] LAST_IDX = 2'(NUM_MASTERS - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] beats_q, beats_d;

  logic       win_found;
  logic [1:0] win_idx;
  req_t       req [NUM_MASTERS];
  req_t       sel_req;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    localparam logic [1:0] IDX = 2'(i);
    logic sel;

    assign req[i] = {m_is_write[i], m_size[3*i +: 3], m_addr[32*i +: 32],
                     m_strobe[4*i +: 4], m_data[32*i +: 32], m_len[4*i +: 4]};

    assign sel                = busy && (grant_q == IDX);
    assign m_ready[i]         = sel & o_ready;
    assign m_last[i]          = sel & o_last;
    assign m_rdata[32*i +: 32] = sel ? o_rdata : 32'd0;
  end

  // Rotating priority: lowest valid index at or above ptr, else lowest valid index overall.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_valid[i] && (2'(i) >= ptr_q)) begin
        win_found = 1'b1;
        win_idx   = 2'(i);
      end
    end
    if (!win_found) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (m_valid[i]) begin
          win_found = 1'b1;
          win_idx   = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          grant_d = win_idx;
          beats_d = 4'd0;
        end
      end
      BUSY: begin
        if (o_ready) begin
          beats_d = beats_q + 4'd1;
        end
        // Grant is released only on the last beat; re-arbitration waits one cycle in IDLE.
        if (o_ready && o_last) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LAST_IDX) ? 2'd0 : grant_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      beats_q <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beats_q <= beats_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign grant   = grant_q;
  assign sel_req = req[grant_q[IW-1:0]];

  assign o_valid    = busy & m_valid[grant_q[IW-1:0]];
  assign o_is_write = busy ? sel_req.is_write : 1'b0;
  assign o_size     = busy ? sel_req.size     : 3'd0;
  assign o_addr     = busy ? sel_req.addr     : 32'd0;
  assign o_strobe   = busy ? sel_req.strobe   : 4'd0;
  assign o_data     = busy ? sel_req.data     : 32'd0;
  assign o_len      = busy ? sel_req.len      : 4'd0;

endmodule
